fetch_pc_predict: RTL and testbench
===================================

# fetch_pc_predict

Fetch-stage PC generator for the pipelined Y86-64 core, replacing pure combinational PC selection with a registered predicted-PC unit. It owns the F_predPC register, a parametrised return-address stack (RAS) that predicts `ret` targets at fetch, and a pending-return queue that checks each prediction when the `ret` reaches write-back. It redirects fetch on a `jXX` mispredict from M or a `ret` mispredict from W. It sits between the fetch decode logic and pipeline control.

## Interface
- ADDR_W, 64: PC/address width.
- RAS_DEPTH, 8: return-address stack entries, power of two, ≥2.
- PEND_DEPTH, 4: pending-return queue entries, power of two.
- RESET_PC, 0: F_predPC value after reset.
- clk_i  in  1  core clock, all state on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- F_stall_i  in  1  fetch stalled; the instruction at f_pc is not accepted this cycle.
- f_icode_i  in  4  icode of the instruction fetched at f_pc_o.
- f_valC_i  in  ADDR_W  constant word of the fetched instruction.
- f_valP_i  in  ADDR_W  fall-through PC of the fetched instruction.
- M_icode_i, M_Cnd_i, M_valA_i  in  4/1/ADDR_W  memory-stage icode, condition, and fall-through PC.
- W_icode_i, W_valM_i  in  4/ADDR_W  write-back icode and loaded return address.
- f_pc_o  out  ADDR_W  PC to fetch this cycle.
- F_predPC_o  out  ADDR_W  registered predicted PC.
- f_ret_pred_o  out  1  the fetched `ret` has a RAS prediction; control does not insert ret bubbles.
- redirect_o  out  1  f_pc_o is a correction, not F_predPC.
- ras_cnt_o  out  $clog2(RAS_DEPTH)+1  valid RAS entries.

## Operation
- Fire: an instruction fires when F_stall_i=0. Push, pop, and enqueue happen only on fire.
- f_pc_o priority:
  - W ret mispredict: W_icode=IRET, and either the queue head is unpredicted, the queue is empty, or the head target ≠ W_valM. Output W_valM_i.
  - Else M jXX mispredict: M_icode=IJXX and !M_Cnd. Output M_valA_i.
  - Else output F_predPC.
- Priority rationale: a mispredicted `ret` is older than any `jXX` in M, so the `ret` correction wins.
- Next predPC, by fetched icode:
  - IJXX or ICALL: f_valC.
  - IRET with RAS non-empty and queue not full: RAS top.
  - Any other case: f_valP.
- ICALL push: push f_valP. When the RAS is full, overwrite the oldest entry circularly; ras_cnt saturates at RAS_DEPTH.
- IRET handling:
  - Pop when predicted and set f_ret_pred_o=1.
  - Enqueue {pred, target} into the pending queue whenever the queue is not full.
  - An unpredicted `ret` enqueues pred=0 when space allows. When the queue is full it is not enqueued and is unpredicted.
- W_icode=IRET: pop the queue head each cycle this holds. Each instruction occupies W for exactly one cycle.
- Any redirect:
  - Clear the RAS (cnt=0) and the pending queue, applied after the W pop.
  - Then apply the current fetch's push/pop/enqueue against the emptied structures. The fetched instruction is on the correct path.
- On redirect, an IRET at fetch is unpredicted. An ICALL at fetch pushes into the empty RAS.

## Timing
- f_pc_o, redirect_o, and f_ret_pred_o are combinational, same cycle, from registered state plus M/W/f inputs.
- F_predPC, RAS, and queue update on the rising edge. A push in cycle n is poppable in n+1, so call-then-ret back to back is predicted.
- Stall: F_stall_i=1 freezes F_predPC, RAS, and queue enqueue. The W-side pop and redirect flush still occur.
- Reset, asynchronous and at any time including mid-operation:
  - F_predPC=RESET_PC, RAS cnt=0, queue empty.
  - Outputs: f_pc_o=RESET_PC (absent M/W redirect), redirect_o=0, f_ret_pred_o=0, ras_cnt_o=0.
- Queue wrap: pointers wrap modulo PEND_DEPTH; full/empty are decided by an extra pointer bit.

## Structure
- IJXX, ICALL, IRET, INOP come from the shared define.v constants; no new icodes.
- Sub-module ras_stack (parametrised ADDR_W/RAS_DEPTH) provides push/pop/clear, top, and cnt, with circular overwrite.
- The pending queue is a small inline FIFO in the top.

## Test plan
- Reset with RESET_PC=0x100, idle inputs: f_pc_o=0x100, ras_cnt_o=0, redirect_o=0.
- Call/ret pair:
  - Stimulus: ICALL at 0x100 with valC=0x200 and valP=0x109, then IRET fetched next cycle.
  - Required: predPC=0x200, f_ret_pred_o=1, next predPC=0x109.
  - Later W IRET with W_valM=0x109: redirect_o=0.
- Predicted ret, wrong target: W IRET with W_valM=0x300 ≠ queued 0x109 → f_pc_o=0x300, redirect_o=1, ras_cnt_o=0 next cycle.
- jXX mispredict: M_icode=IJXX, M_Cnd=0, M_valA=0x40 → f_pc_o=0x40, RAS and queue flushed.
- Simultaneous correction sources:
  - Stimulus: W ret mispredict to 0x500 and M jXX mispredict to 0x40 in the same cycle.
  - Required: f_pc_o=0x500.
- Overflow:
  - Stimulus: RAS_DEPTH+2 calls with valP=0x10..0x19.
  - Required: ras_cnt_o saturates at 8; successive rets predict 0x19 down to 0x12.

Source files
------------

// File: rtl/fetch_pc_predict_pkg.sv
// Shared Y86-64 icodes and next-PC selection for the fetch PC predictor.
// Pure combinational helpers; no state, no flow control.
package fetch_pc_predict_pkg;

    localparam logic [3:0] INOP  = 4'h1;
    localparam logic [3:0] IJXX  = 4'h7;
    localparam logic [3:0] ICALL = 4'h8;
    localparam logic [3:0] IRET  = 4'h9;

    typedef enum logic [1:0] {
        NPC_VALP,
        NPC_VALC,
        NPC_RAS
    } npc_sel_e;

    function automatic npc_sel_e npc_sel(input logic [3:0] icode, input logic ret_pred);
        if (icode == IJXX || icode == ICALL) return NPC_VALC;
        if (icode == IRET && ret_pred)        return NPC_RAS;
        return NPC_VALP;
    endfunction

endpackage

// File: rtl/fetch_pc_predict_ras.sv
// Circular return-address stack: push/pop/clear, top-of-stack and entry count.
// Top is combinational from state; updates land on the next rising edge.
// No backpressure: a push on a full stack overwrites the oldest entry.
module ras_stack #(
    parameter int ADDR_W    = 64,
    parameter int RAS_DEPTH = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clear_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [ADDR_W-1:0]            push_dat_i,
    output logic [ADDR_W-1:0]            top_dat_o,
    output logic [$clog2(RAS_DEPTH):0]   cnt_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_idx;

    // Clear only drops the count; the write pointer keeps rotating so a
    // push in the same cycle lands on a fresh slot.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = clear_i ? '0 : cnt_q;
        if (push_i) begin
            mem_d[wr_ptr_q] = push_dat_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
            if (cnt_d != FULL_CNT) cnt_d = cnt_d + 1'b1;
        end else if (pop_i && cnt_d != '0) begin
            wr_ptr_d = wr_ptr_q - 1'b1;
            cnt_d    = cnt_d - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            mem_q    <= mem_d;
        end
    end

    assign top_idx   = wr_ptr_q - 1'b1;
    assign top_dat_o = mem_q[top_idx];
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/fetch_pc_predict.sv
// Fetch PC generator: registered predPC, RAS ret prediction, W-stage ret check.
// f_pc/redirect/ret_pred are same-cycle combinational; state updates on the edge.
// F_stall_i freezes predPC, push/pop and enqueue; W pop and redirect flush still apply.
module fetch_pc_predict
    import fetch_pc_predict_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                RAS_DEPTH  = 8,
    parameter int                PEND_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        F_stall_i,
    input  logic [3:0]                  f_icode_i,
    input  logic [ADDR_W-1:0]           f_valC_i,
    input  logic [ADDR_W-1:0]           f_valP_i,
    input  logic [3:0]                  M_icode_i,
    input  logic                        M_Cnd_i,
    input  logic [ADDR_W-1:0]           M_valA_i,
    input  logic [3:0]                  W_icode_i,
    input  logic [ADDR_W-1:0]           W_valM_i,
    output logic [ADDR_W-1:0]           f_pc_o,
    output logic [ADDR_W-1:0]           F_predPC_o,
    output logic                        f_ret_pred_o,
    output logic                        redirect_o,
    output logic [$clog2(RAS_DEPTH):0]  ras_cnt_o
);

    localparam int PQ_W = $clog2(PEND_DEPTH);

    logic [ADDR_W-1:0]         predpc_q, predpc_d;
    logic [PQ_W:0]             rd_q, rd_d, wr_q, wr_d;
    logic [PEND_DEPTH-1:0]     pend_pred_q, pend_pred_d;
    logic [ADDR_W-1:0]         pend_tgt_q [PEND_DEPTH];
    logic [ADDR_W-1:0]         pend_tgt_d [PEND_DEPTH];

    logic                      fire;
    logic                      f_is_call, f_is_ret;
    logic                      q_empty, q_full;
    logic [PQ_W-1:0]           head_idx, tail_idx;
    logic                      w_ret, w_mispred, m_mispred, redirect;
    logic                      ret_pred, enq_ok;
    logic [ADDR_W-1:0]         ras_top;
    logic [$clog2(RAS_DEPTH):0] ras_cnt;

    assign fire      = !F_stall_i;
    assign f_is_call = (f_icode_i == ICALL);
    assign f_is_ret  = (f_icode_i == IRET);

    assign head_idx  = rd_q[PQ_W-1:0];
    assign tail_idx  = wr_q[PQ_W-1:0];
    assign q_empty   = (rd_q == wr_q);
    assign q_full    = (rd_q[PQ_W] != wr_q[PQ_W]) && (head_idx == tail_idx);

    // A ret reaching W with no matching prediction at the queue head means
    // fetch went down the wrong path; it is older than any jXX in M.
    assign w_ret     = (W_icode_i == IRET);
    assign w_mispred = w_ret && (q_empty || !pend_pred_q[head_idx] ||
                                 pend_tgt_q[head_idx] != W_valM_i);
    assign m_mispred = (M_icode_i == IJXX) && !M_Cnd_i;
    assign redirect  = w_mispred || m_mispred;

    always_comb begin
        f_pc_o = predpc_q;
        if (w_mispred)      f_pc_o = W_valM_i;
        else if (m_mispred) f_pc_o = M_valA_i;
    end

    // On redirect the stacks are flushed before this fetch sees them, so a
    // ret here can never be predicted but always finds queue space.
    assign ret_pred = f_is_ret && !redirect && (ras_cnt != '0) && !q_full;
    assign enq_ok   = redirect || !q_full;

    always_comb begin
        predpc_d = predpc_q;
        if (fire) begin
            case (npc_sel(f_icode_i, ret_pred))
                NPC_VALC: predpc_d = f_valC_i;
                NPC_RAS:  predpc_d = ras_top;
                default:  predpc_d = f_valP_i;
            endcase
        end
    end

    always_comb begin
        rd_d        = rd_q;
        wr_d        = wr_q;
        pend_pred_d = pend_pred_q;
        pend_tgt_d  = pend_tgt_q;
        if (w_ret && !q_empty) rd_d = rd_q + 1'b1;
        if (redirect)          rd_d = wr_q;
        if (fire && f_is_ret && enq_ok) begin
            pend_pred_d[tail_idx] = ret_pred;
            pend_tgt_d[tail_idx]  = ras_top;
            wr_d                  = wr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            predpc_q    <= RESET_PC;
            rd_q        <= '0;
            wr_q        <= '0;
            pend_pred_q <= '0;
            for (int i = 0; i < PEND_DEPTH; i++) pend_tgt_q[i] <= '0;
        end else begin
            predpc_q    <= predpc_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            pend_pred_q <= pend_pred_d;
            pend_tgt_q  <= pend_tgt_d;
        end
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .clear_i    (redirect),
        .push_i     (fire && f_is_call),
        .pop_i      (fire && ret_pred),
        .push_dat_i (f_valP_i),
        .top_dat_o  (ras_top),
        .cnt_o      (ras_cnt)
    );

    assign F_predPC_o   = predpc_q;
    assign f_ret_pred_o = ret_pred;
    assign redirect_o   = redirect;
    assign ras_cnt_o    = ras_cnt;

endmodule

// File: tb/tb_fetch_pc_predict.sv
// Directed bench for fetch_pc_predict: call/ret prediction, W/M redirects, queue and RAS limits.
module tb_fetch_pc_predict;
    import fetch_pc_predict_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [3:0]  f_icode;
    logic [63:0] f_valC, f_valP;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] f_pc, predpc;
    logic        ret_pred, redirect;
    logic [3:0]  ras_cnt;

    int checks = 0;
    int errors = 0;

    fetch_pc_predict #(
        .ADDR_W     (64),
        .RAS_DEPTH  (8),
        .PEND_DEPTH (4),
        .RESET_PC   (64'h100)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .F_stall_i    (stall),
        .f_icode_i    (f_icode),
        .f_valC_i     (f_valC),
        .f_valP_i     (f_valP),
        .M_icode_i    (M_icode),
        .M_Cnd_i      (M_Cnd),
        .M_valA_i     (M_valA),
        .W_icode_i    (W_icode),
        .W_valM_i     (W_valM),
        .f_pc_o       (f_pc),
        .F_predPC_o   (predpc),
        .f_ret_pred_o (ret_pred),
        .redirect_o   (redirect),
        .ras_cnt_o    (ras_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall   = 1'b1;
        f_icode = INOP;
        f_valC  = '0;
        f_valP  = '0;
        M_icode = INOP;
        M_Cnd   = 1'b0;
        M_valA  = '0;
        W_icode = INOP;
        W_valM  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        stall   = 1'b0;
        f_icode = ic;
        f_valC  = vc;
        f_valP  = vp;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        #12;
        checks++; if (f_pc !== 64'h100) begin errors++; $display("FAIL reset_f_pc: got %h need %h", f_pc, 64'h100); end
        checks++; if (predpc !== 64'h100) begin errors++; $display("FAIL reset_predpc: got %h need %h", predpc, 64'h100); end
        checks++; if (ras_cnt !== 4'd0) begin errors++; $display("FAIL reset_ras_cnt: got %0d need 0", ras_cnt); end
        checks++; if (redirect !== 1'b0 || ret_pred !== 1'b0) begin errors++; $display("FAIL reset_flags: redirect %b ret_pred %b need 0 0", redirect, ret_pred); end
        rst_n = 1'b1;
        step();
        checks++; if (f_pc !== 64'h100) begin errors++; $display("FAIL reset_hold: got %h need %h", f_pc, 64'h100); end
    endtask

    task automatic test_call_ret();
        fetch(ICALL, 64'h200, 64'h109);
        #1;
        checks++; if (f_pc !== 64'h100 || redirect !== 1'b0) begin errors++; $display("FAIL call_fpc: got %h/%b need 100/0", f_pc, redirect); end
        step();
        checks++; if (predpc !== 64'h200 || ras_cnt !== 4'd1) begin errors++; $display("FAIL call_pred: got %h cnt %0d need 200 cnt 1", predpc, ras_cnt); end
        fetch(IRET, 64'h0, 64'h201);
        #1;
        checks++; if (ret_pred !== 1'b1) begin errors++; $display("FAIL ret_pred_b2b: got %b need 1", ret_pred); end
        step();
        checks++; if (predpc !== 64'h109 || ras_cnt !== 4'd0) begin errors++; $display("FAIL ret_target: got %h cnt %0d need 109 cnt 0", predpc, ras_cnt); end
        idle();
        W_icode = IRET; W_valM = 64'h109;
        #1;
        checks++; if (redirect !== 1'b0 || f_pc !== 64'h109) begin errors++; $display("FAIL w_ret_ok: redirect %b f_pc %h need 0 109", redirect, f_pc); end
        step();
        idle();
    endtask

    task automatic test_ret_wrong();
        fetch(ICALL, 64'h200, 64'h109); step();
        fetch(ICALL, 64'h280, 64'h209); step();
        fetch(ICALL, 64'h380, 64'h309); step();
        fetch(IRET, 64'h0, 64'h381); step();
        checks++; if (predpc !== 64'h309) begin errors++; $display("FAIL ret1_target: got %h need 309", predpc); end
        fetch(IRET, 64'h0, 64'h30a); step();
        checks++; if (predpc !== 64'h209 || ras_cnt !== 4'd1) begin errors++; $display("FAIL ret2_target: got %h cnt %0d need 209 cnt 1", predpc, ras_cnt); end
        idle();
        W_icode = IRET; W_valM = 64'h300;
        #1;
        checks++; if (f_pc !== 64'h300 || redirect !== 1'b1) begin errors++; $display("FAIL w_ret_wrong: f_pc %h redirect %b need 300 1", f_pc, redirect); end
        step();
        checks++; if (ras_cnt !== 4'd0) begin errors++; $display("FAIL w_flush_ras: got %0d need 0", ras_cnt); end
        W_valM = 64'h209;
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL w_flush_queue: redirect %b need 1", redirect); end
        step();
        idle();
    endtask

    task automatic test_jxx();
        fetch(ICALL, 64'h600, 64'h50); step();
        fetch(ICALL, 64'h700, 64'h60); step();
        fetch(IRET, 64'h0, 64'h701); step();
        idle();
        M_icode = IJXX; M_Cnd = 1'b1; M_valA = 64'h40;
        #1;
        checks++; if (redirect !== 1'b0 || f_pc !== 64'h60) begin errors++; $display("FAIL jxx_taken_ok: redirect %b f_pc %h need 0 60", redirect, f_pc); end
        M_Cnd = 1'b0;
        #1;
        checks++; if (redirect !== 1'b1 || f_pc !== 64'h40) begin errors++; $display("FAIL jxx_mispred: redirect %b f_pc %h need 1 40", redirect, f_pc); end
        step();
        M_icode = INOP;
        checks++; if (ras_cnt !== 4'd0) begin errors++; $display("FAIL jxx_flush_ras: got %0d need 0", ras_cnt); end
        W_icode = IRET; W_valM = 64'h60;
        #1;
        checks++; if (redirect !== 1'b1) begin errors++; $display("FAIL jxx_flush_queue: redirect %b need 1", redirect); end
        step();
        idle();
    endtask

    task automatic test_redirect_fetch();
        fetch(ICALL, 64'h800, 64'h70); step();
        fetch(IRET, 64'h0, 64'h41);
        M_icode = IJXX; M_Cnd = 1'b0; M_valA = 64'h40;
        #1;
        checks++; if (ret_pred !== 1'b0) begin errors++; $display("FAIL redir_ret_unpred: got %b need 0", ret_pred); end
        step();
        checks++; if (predpc !== 64'h41 || ras_cnt !== 4'd0) begin errors++; $display("FAIL redir_ret_next: got %h cnt %0d need 41 cnt 0", predpc, ras_cnt); end
        fetch(ICALL, 64'h900, 64'h45);
        step();
        checks++; if (predpc !== 64'h900 || ras_cnt !== 4'd1) begin errors++; $display("FAIL redir_call_push: got %h cnt %0d need 900 cnt 1", predpc, ras_cnt); end
        idle();
    endtask

    task automatic test_simultaneous();
        W_icode = IRET; W_valM = 64'h500;
        M_icode = IJXX; M_Cnd = 1'b0; M_valA = 64'h40;
        #1;
        checks++; if (f_pc !== 64'h500 || redirect !== 1'b1) begin errors++; $display("FAIL w_over_m: f_pc %h redirect %b need 500 1", f_pc, redirect); end
        step();
        checks++; if (ras_cnt !== 4'd0) begin errors++; $display("FAIL simul_flush: got %0d need 0", ras_cnt); end
        idle();
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < 5; i++) begin
            fetch(ICALL, 64'hb00, 64'(64'ha0 + i)); step();
        end
        for (int k = 0; k < 4; k++) begin
            fetch(IRET, 64'h0, 64'hc0);
            #1;
            checks++; if (ret_pred !== 1'b1) begin errors++; $display("FAIL qfull_pred_%0d: got %b need 1", k, ret_pred); end
            step();
            checks++; if (predpc !== 64'(64'ha4 - k)) begin errors++; $display("FAIL qfull_tgt_%0d: got %h need %h", k, predpc, 64'(64'ha4 - k)); end
        end
        fetch(IRET, 64'h0, 64'hc5);
        #1;
        checks++; if (ret_pred !== 1'b0) begin errors++; $display("FAIL qfull_unpred: got %b need 0", ret_pred); end
        step();
        checks++; if (predpc !== 64'hc5 || ras_cnt !== 4'd1) begin errors++; $display("FAIL qfull_next: got %h cnt %0d need c5 cnt 1", predpc, ras_cnt); end
        idle();
        M_icode = IJXX; M_Cnd = 1'b0; M_valA = 64'h40;
        step();
        idle();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) begin
            fetch(ICALL, 64'h1000, 64'(64'h10 + i)); step();
        end
        checks++; if (ras_cnt !== 4'd8) begin errors++; $display("FAIL ovf_cnt: got %0d need 8", ras_cnt); end
        for (int k = 0; k < 8; k++) begin
            fetch(IRET, 64'h0, 64'h2000);
            if (k > 0) begin W_icode = IRET; W_valM = 64'(64'h19 - (k - 1)); end
            #1;
            checks++; if (ret_pred !== 1'b1 || redirect !== 1'b0) begin errors++; $display("FAIL ovf_ret_%0d: pred %b redirect %b need 1 0", k, ret_pred, redirect); end
            step();
            checks++; if (predpc !== 64'(64'h19 - k)) begin errors++; $display("FAIL ovf_tgt_%0d: got %h need %h", k, predpc, 64'(64'h19 - k)); end
        end
        fetch(IRET, 64'h0, 64'h2000);
        W_icode = IRET; W_valM = 64'h12;
        #1;
        checks++; if (ret_pred !== 1'b0 || redirect !== 1'b0) begin errors++; $display("FAIL ovf_empty: pred %b redirect %b need 0 0", ret_pred, redirect); end
        step();
        idle();
        checks++; if (predpc !== 64'h2000) begin errors++; $display("FAIL ovf_empty_next: got %h need 2000", predpc); end
    endtask

    task automatic test_reset_mid();
        fetch(ICALL, 64'h3000, 64'h77); step();
        idle();
        rst_n = 1'b0;
        #1;
        checks++; if (predpc !== 64'h100 || ras_cnt !== 4'd0 || f_pc !== 64'h100) begin errors++; $display("FAIL reset_mid: pred %h cnt %0d f_pc %h need 100 0 100", predpc, ras_cnt, f_pc); end
        #2;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_ret_wrong();
        test_jxx();
        test_redirect_fetch();
        test_simultaneous();
        test_queue_full();
        test_overflow();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
